data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Arbitrates the single-port data memory between two requesters:
//  port 0 (CPU load/store) and port 1 (loader/debug DMA).
//  Drives the memory's write enable, address and write data.
//  Registers read data and returns it with a valid pulse.
//  Contains a clear sequencer that writes CLR_VALUE to every address, one address per cycle.
// PARAMETERS
//  ADDR_W     8     memory address width (depth = 2**ADDR_W)
//  DATA_W     8     memory data width
//  CLR_VALUE  8'h00 value written to every word by the clear sequence
//  FIXED_PRIO 0     0 = round-robin between ports; 1 = port 0 always wins
// PORTS
//  clk        in   1       system clock, all state updates on posedge
//  reset      in   1       synchronous, ACTIVE-LOW reset
//  r0_req     in   1       port 0 access request
//  r0_we      in   1       port 0: 1 = write, 0 = read
//  r0_addr    in   ADDR_W  port 0 address
//  r0_wdata   in   DATA_W  port 0 write data
//  r0_gnt     out  1       port 0 granted this cycle (combinational)
//  r0_rvalid  out  1       port 0 read data valid (registered pulse)
//  r0_rdata   out  DATA_W  port 0 read data (registered)
//  r1_*       ---  ---     same set as r0_*, for port 1
//  clr_start  in   1       start clear sequence (sampled in IDLE only)
//  clr_busy   out  1       clear sequence in progress
//  clr_done   out  1       one-cycle pulse after the last clear write
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data (combinational from mem_addr)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE, clr_cnt=0, last_gnt=1 (port 0 wins the first tie).
//   - r*_rvalid=0, r*_rdata=0, clr_busy=0, clr_done=0.
//   - While reset==0, r*_gnt=0 and mem_we=0.
//  FSM, IDLE:
//   - Arbitration is combinational; at most one gnt per cycle.
//   - One requester active -> it is granted.
//   - Both active:
//     - FIXED_PRIO=1 -> port 0 wins.
//     - FIXED_PRIO=0 -> the port not in last_gnt wins.
//   - last_gnt updates at posedge on every grant.
//   - mem_we/addr/wdata are driven from the granted port; no grant -> mem_we=0.
//   - Granted read: mem_rdata is captured into rX_rdata at posedge; rX_rvalid=1 in the next cycle only.
//   - Granted write: no rvalid.
//   - A requester holds req/we/addr/wdata until it sees gnt. A grant completes in 1 cycle.
//   - Back-to-back grants to the same port are allowed when the other port is idle.
//   - Ungranted rX_rdata holds its last value.
//   - clr_start=1 -> CLEAR at next edge, clr_cnt=0.
//     - Grants in that same cycle still proceed.
//  FSM, CLEAR:
//   - clr_busy=1, all gnt=0 (requesters stall).
//   - mem_we=1, mem_addr=clr_cnt, mem_wdata=CLR_VALUE; clr_cnt increments each cycle.
//   - After the write to 2**ADDR_W-1 -> IDLE; clr_done=1 for the first IDLE cycle.
//   - Duration is exactly 2**ADDR_W cycles (256 by default).
//   - clr_start during CLEAR is ignored (no restart, no queueing).
//   - clr_cnt is compared against all-ones; no wrap past the top address.
//  Reset mid-CLEAR -> IDLE immediately:
//   - No clr_done; memory is left partially cleared.
//  Read in flight when clear starts:
//   - That read's rvalid still asserts in the first CLEAR cycle.
// TESTING
//  1. Reset held low 2 cycles -> all outputs 0, mem_we=0, even with r0_req=1 r0_we=1.
//  2. r0 writes 8'hA5 to addr 8'h10, then r1 reads addr 8'h10:
//     - r1_gnt is seen the cycle after r0_gnt.
//     - r1_rvalid=1 with r1_rdata=8'hA5 one cycle after r1_gnt.
//  3. Both ports request continuously (reads, addr 8'h01 / 8'h02), FIXED_PRIO=0:
//     - Grants alternate r0,r1,r0,r1; no cycle has both gnt.
//     - Same with FIXED_PRIO=1 -> r0 granted every cycle.
//  4. Preload addr 0, 8'h80, 8'hFF with 8'h5A, pulse clr_start:
//     - clr_busy=1 for 256 cycles, clr_done pulses once.
//     - Reads of all three addresses then return 8'h00.
//  5. r0_req=1 throughout CLEAR -> r0_gnt=0 until clr_done cycle, granted in that cycle.
//     - clr_start pulsed at cycle 100 of CLEAR -> no extension.
//  6. reset=0 at CLEAR cycle 50 -> IDLE, clr_done never pulses.
//     - addr 49 reads 8'h00, addr 60 keeps its preloaded 8'h5A.

Source files
------------

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Two-port arbiter for a single-port data memory, with a
//            whole-memory clear sequencer.
// Revision : 1.0
// ============================================================================
module data_mem_arbiter #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] CLR_VALUE  = '0,
   parameter bit                FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [ADDR_W-1:0] w_clr_cnt_nxt;
   logic              r_last_gnt;
   logic              r_clr_done;
   logic              w_clr_done_nxt;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_cnt_nxt  = r_clr_cnt;
      w_clr_done_nxt = 1'b0;
      w_gnt0         = 1'b0;
      w_gnt1         = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_addr     = '0;
      w_mem_wdata    = '0;
      case (r_state)
         ST_IDLE: begin
            // r_last_gnt==1 means port 1 was served last, so port 0 wins a tie
            if (r0_req && r1_req) begin
               if (FIXED_PRIO || r_last_gnt) begin
                  w_gnt0 = 1'b1;
               end else begin
                  w_gnt1 = 1'b1;
               end
            end else begin
               w_gnt0 = r0_req;
               w_gnt1 = r1_req;
            end
            if (w_gnt0) begin
               w_mem_we    = r0_we;
               w_mem_addr  = r0_addr;
               w_mem_wdata = r0_wdata;
            end else if (w_gnt1) begin
               w_mem_we    = r1_we;
               w_mem_addr  = r1_addr;
               w_mem_wdata = r1_wdata;
            end
            if (clr_start) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_cnt_nxt = '0;
            end
         end
         ST_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = CLR_VALUE;
            if (&r_clr_cnt) begin
               w_state_nxt    = ST_IDLE;
               w_clr_done_nxt = 1'b1;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Nothing reaches the memory or the requesters while reset is asserted
      if (!reset) begin
         w_gnt0   = 1'b0;
         w_gnt1   = 1'b0;
         w_mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_clr_cnt  <= '0;
         r_last_gnt <= 1'b1;
         r_clr_done <= 1'b0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_cnt  <= w_clr_cnt_nxt;
         r_clr_done <= w_clr_done_nxt;
         if (w_gnt0) begin
            r_last_gnt <= 1'b0;
         end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
         end
         r_rvalid0 <= w_gnt0 & ~r0_we;
         r_rvalid1 <= w_gnt1 & ~r1_we;
         if (w_gnt0 && !r0_we) begin
            r_rdata0 <= mem_rdata;
         end
         if (w_gnt1 && !r1_we) begin
            r_rdata1 <= mem_rdata;
         end
      end
   end

   assign r0_gnt    = w_gnt0;
   assign r1_gnt    = w_gnt1;
   assign r0_rvalid = r_rvalid0;
   assign r1_rvalid = r_rvalid1;
   assign r0_rdata  = r_rdata0;
   assign r1_rdata  = r_rdata1;
   assign clr_busy  = (r_state == ST_CLEAR);
   assign clr_done  = r_clr_done;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Directed self-checking bench for data_mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

   logic       clk;
   logic       reset;
   logic       r0_req, r0_we, r1_req, r1_we, clr_start;
   logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

   logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, clr_busy, clr_done, mem_we;
   logic [7:0] r0_rdata, r1_rdata, mem_addr, mem_wdata, mem_rdata;

   logic       f_r0_gnt, f_r0_rvalid, f_r1_gnt, f_r1_rvalid, f_clr_busy, f_clr_done, f_mem_we;
   logic [7:0] f_r0_rdata, f_r1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;

   logic [7:0] mem  [256];
   logic [7:0] fmem [256];

   int n_assert = 0;
   int n_fail   = 0;

   data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CLR_VALUE(8'h00), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CLR_VALUE(8'h00), .FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(f_r0_gnt), .r0_rvalid(f_r0_rvalid), .r0_rdata(f_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(f_r1_gnt), .r1_rvalid(f_r1_rvalid), .r1_rdata(f_r1_rdata),
      .clr_start(clr_start), .clr_busy(f_clr_busy), .clr_done(f_clr_done),
      .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'(i) ^ 8'h3C;
         fmem[i] = 8'(i) ^ 8'h3C;
      end
   end

   always @(posedge clk) begin
      if (mem_we)   mem[mem_addr]    <= mem_wdata;
      if (f_mem_we) fmem[f_mem_addr] <= f_mem_wdata;
   end

   assign mem_rdata   = mem[mem_addr];
   assign f_mem_rdata = fmem[f_mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = addr; r0_wdata = data;
      @(negedge clk);
      check("wr_gnt", {31'd0, r0_gnt}, 32'd1);
      next_cycle();
      r0_req = 1'b0; r0_we = 1'b0;
   endtask

   task automatic do_read(input bit port, input logic [7:0] addr, input logic [7:0] exp, input string tag);
      if (!port) begin
         r0_req = 1'b1; r0_we = 1'b0; r0_addr = addr;
      end else begin
         r1_req = 1'b1; r1_we = 1'b0; r1_addr = addr;
      end
      @(negedge clk);
      check({tag, "_gnt"}, {31'd0, port ? r1_gnt : r0_gnt}, 32'd1);
      next_cycle();
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);
      check({tag, "_rvalid"}, {31'd0, port ? r1_rvalid : r0_rvalid}, 32'd1);
      check({tag, "_rdata"}, {24'd0, port ? r1_rdata : r0_rdata}, {24'd0, exp});
      next_cycle();
   endtask

   initial begin
      // Reset held low for two edges while port 0 presses a write
      reset = 1'b0; clr_start = 1'b0;
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h03; r0_wdata = 8'h77;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rst_r0_gnt",    {31'd0, r0_gnt},    32'd0);
      check("rst_r1_gnt",    {31'd0, r1_gnt},    32'd0);
      check("rst_mem_we",    {31'd0, mem_we},    32'd0);
      check("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      check("rst_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
      check("rst_r0_rdata",  {24'd0, r0_rdata},  32'd0);
      check("rst_r1_rdata",  {24'd0, r1_rdata},  32'd0);
      check("rst_clr_busy",  {31'd0, clr_busy},  32'd0);
      check("rst_clr_done",  {31'd0, clr_done},  32'd0);
      check("rst_fix_gnt",   {31'd0, f_r0_gnt},  32'd0);
      next_cycle();

      // r0 writes A5 to 0x10, then r1 reads it back
      reset = 1'b1;
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h10; r0_wdata = 8'hA5;
      @(negedge clk);
      check("t2_r0_gnt",  {31'd0, r0_gnt},    32'd1);
      check("t2_r1_gnt0", {31'd0, r1_gnt},    32'd0);
      check("t2_we",      {31'd0, mem_we},    32'd1);
      check("t2_addr",    {24'd0, mem_addr},  32'h10);
      check("t2_wdata",   {24'd0, mem_wdata}, 32'hA5);
      next_cycle();
      r0_req = 1'b0; r0_we = 1'b0;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
      @(negedge clk);
      check("t2_r1_gnt",  {31'd0, r1_gnt},   32'd1);
      check("t2_r0_gnt0", {31'd0, r0_gnt},   32'd0);
      check("t2_rd_we",   {31'd0, mem_we},   32'd0);
      check("t2_rd_addr", {24'd0, mem_addr}, 32'h10);
      next_cycle();
      r1_req = 1'b0;
      @(negedge clk);
      check("t2_r1_rvalid", {31'd0, r1_rvalid}, 32'd1);
      check("t2_r1_rdata",  {24'd0, r1_rdata},  32'hA5);
      check("t2_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
      next_cycle();
      @(negedge clk);
      check("t2_r1_rvalid_end", {31'd0, r1_rvalid}, 32'd0);
      check("t2_r1_rdata_hold", {24'd0, r1_rdata},  32'hA5);
      next_cycle();

      // Both ports read continuously: alternate (round-robin) / r0 always (fixed)
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h01;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h02;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t3_rr_r0_gnt",  {31'd0, r0_gnt},   {31'd0, (i % 2) == 0});
         check("t3_rr_r1_gnt",  {31'd0, r1_gnt},   {31'd0, (i % 2) == 1});
         check("t3_fix_r0_gnt", {31'd0, f_r0_gnt}, 32'd1);
         check("t3_fix_r1_gnt", {31'd0, f_r1_gnt}, 32'd0);
         if (i >= 1) begin
            check("t3_r0_rvalid", {31'd0, r0_rvalid}, {31'd0, (i % 2) == 1});
            check("t3_r1_rvalid", {31'd0, r1_rvalid}, {31'd0, (i % 2) == 0});
         end
         if (i >= 2 && (i % 2) == 0) begin
            check("t3_r1_rdata", {24'd0, r1_rdata}, 32'h3E);
         end
         if (i % 2 == 1) begin
            check("t3_r0_rdata", {24'd0, r0_rdata}, 32'h3D);
         end
         next_cycle();
      end
      r0_req = 1'b0; r1_req = 1'b0;
      next_cycle();

      // Preload, then clear with r1 read in flight and r0 stalled throughout
      do_write(8'h00, 8'h5A);
      do_write(8'h80, 8'h5A);
      do_write(8'hFF, 8'h5A);
      clr_start = 1'b1;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h80;
      @(negedge clk);
      check("t4_start_r1_gnt", {31'd0, r1_gnt},   32'd1);
      check("t4_start_busy",   {31'd0, clr_busy}, 32'd0);
      next_cycle();
      clr_start = 1'b0; r1_req = 1'b0;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h80;
      for (int k = 0; k < 256; k++) begin
         clr_start = (k == 100);
         @(negedge clk);
         if (k == 0) begin
            check("t4_inflight_rvalid", {31'd0, r1_rvalid}, 32'd1);
            check("t4_inflight_rdata",  {24'd0, r1_rdata},  32'h5A);
         end
         check("t4_busy",   {31'd0, clr_busy},  32'd1);
         check("t4_done",   {31'd0, clr_done},  32'd0);
         check("t4_r0_gnt", {31'd0, r0_gnt},    32'd0);
         check("t4_we",     {31'd0, mem_we},    32'd1);
         check("t4_addr",   {24'd0, mem_addr},  {24'd0, 8'(k)});
         check("t4_wdata",  {24'd0, mem_wdata}, 32'd0);
         next_cycle();
      end
      clr_start = 1'b0;
      @(negedge clk);
      check("t4_done_pulse", {31'd0, clr_done}, 32'd1);
      check("t4_busy_end",   {31'd0, clr_busy}, 32'd0);
      check("t5_r0_gnt",     {31'd0, r0_gnt},   32'd1);
      check("t5_r0_addr",    {24'd0, mem_addr}, 32'h80);
      next_cycle();
      r0_req = 1'b0;
      @(negedge clk);
      check("t4_done_once",  {31'd0, clr_done},  32'd0);
      check("t4_busy_idle",  {31'd0, clr_busy},  32'd0);
      check("t5_r0_rvalid",  {31'd0, r0_rvalid}, 32'd1);
      check("t5_r0_rdata",   {24'd0, r0_rdata},  32'h00);
      next_cycle();
      do_read(1'b1, 8'h00, 8'h00, "t4_rd00");
      do_read(1'b1, 8'hFF, 8'h00, "t4_rdFF");

      // Reset abort at clear cycle 50
      do_write(8'd49, 8'h5A);
      do_write(8'd60, 8'h5A);
      clr_start = 1'b1;
      @(negedge clk);
      next_cycle();
      clr_start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (k == 49) begin
            check("t6_addr49", {24'd0, mem_addr}, 32'd49);
         end
         next_cycle();
      end
      reset = 1'b0;
      @(negedge clk);
      check("t6_rst_we",  {31'd0, mem_we}, 32'd0);
      next_cycle();
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t6_busy", {31'd0, clr_busy}, 32'd0);
         check("t6_done", {31'd0, clr_done}, 32'd0);
         next_cycle();
      end
      do_read(1'b0, 8'd60, 8'h5A, "t6_rd60");
      do_read(1'b1, 8'd49, 8'h00, "t6_rd49");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
